// File: rtl/vga_line_prefetcher.sv
// Ping-pong line buffer for the VGA timing generator: prefetches one display line per line-start
// from a single-port, 1-cycle-latency frame memory while sharing that port with one pixel writer.
module vga_line_prefetcher #(
   parameter int H_PIXELS = 640,
   parameter int V_LINES  = 480,
   parameter int ADDR_W   = 19,
   parameter int WR_SLOT  = 8
) (
   input  logic              iClk,
   input  logic              inRst,
   input  logic              iLineStart,
   input  logic [9:0]        iLineNum,
   input  logic              iDataRequest,
   output logic [7:0]        oR,
   output logic [7:0]        oG,
   output logic [7:0]        oB,
   output logic [ADDR_W-1:0] oMemAddr,
   output logic              oMemRd,
   output logic              oMemWr,
   output logic [23:0]       oMemWData,
   input  logic [23:0]       iMemRData,
   input  logic              iWrReq,
   input  logic [ADDR_W-1:0] iWrAddr,
   input  logic [23:0]       iWrData,
   output logic              oWrAck,
   output logic              oBusy,
   output logic              oUnderrun,
   output logic [1:0]        oFsmState
);

   localparam int IDX_W = $clog2(H_PIXELS);
   localparam int CNT_W = $clog2(WR_SLOT);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(H_PIXELS - 1);
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WR_SLOT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                front_q, front_d;
   logic [IDX_W-1:0]    disp_ptr_q, disp_ptr_d;
   logic [IDX_W-1:0]    fill_idx_q, fill_idx_d;
   logic [CNT_W-1:0]    slot_cnt_q, slot_cnt_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic                underrun_q, underrun_d;
   logic                disp_en_q, disp_en_d;
   logic                rd_pend_q, rd_pend_d;
   logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
   logic                rd_buf_q, rd_buf_d;

   logic [23:0]         buf0 [H_PIXELS];
   logic [23:0]         buf1 [H_PIXELS];

   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_rd, mem_wr, wr_ack, wr_ok;
   logic [23:0]         mem_wdata, pix;
   logic [9:0]          line_sel;

   // Writer handshake: iWrReq/iWrAddr/iWrData are held until oWrAck pulses in the cycle the
   // write is issued; the writer drops or replaces the request the following cycle.
   assign wr_ok    = iWrReq & inRst;
   // Out-of-range lines have undefined content; they simply alias to line 0.
   assign line_sel = (iLineNum < 10'(V_LINES)) ? iLineNum : 10'd0;

   always_comb begin
      state_d    = state_q;
      front_d    = front_q;
      disp_ptr_d = disp_ptr_q;
      fill_idx_d = fill_idx_q;
      slot_cnt_d = slot_cnt_q;
      base_d     = base_q;
      underrun_d = underrun_q;
      disp_en_d  = disp_en_q;
      rd_pend_d  = 1'b0;
      rd_idx_d   = rd_idx_q;
      rd_buf_d   = rd_buf_q;
      mem_addr   = '0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_wdata  = '0;
      wr_ack     = 1'b0;

      case (state_q)
         ST_FILL: begin
            slot_cnt_d = (slot_cnt_q == LAST_SLOT) ? '0 : slot_cnt_q + 1'b1;
            if (slot_cnt_q == LAST_SLOT && wr_ok) begin
               mem_wr    = 1'b1;
               mem_addr  = iWrAddr;
               mem_wdata = iWrData;
               wr_ack    = 1'b1;
            end else begin
               mem_rd     = 1'b1;
               mem_addr   = base_q + ADDR_W'(fill_idx_q);
               rd_pend_d  = 1'b1;
               rd_idx_d   = fill_idx_q;
               rd_buf_d   = ~front_q;
               fill_idx_d = fill_idx_q + 1'b1;
               if (fill_idx_q == LAST_IDX) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            state_d = ST_IDLE;
            if (wr_ok) begin
               mem_wr    = 1'b1;
               mem_addr  = iWrAddr;
               mem_wdata = iWrData;
               wr_ack    = 1'b1;
            end
         end
         default: begin
            if (wr_ok) begin
               mem_wr    = 1'b1;
               mem_addr  = iWrAddr;
               mem_wdata = iWrData;
               wr_ack    = 1'b1;
            end
         end
      endcase

      if (iDataRequest && disp_ptr_q != LAST_IDX) disp_ptr_d = disp_ptr_q + 1'b1;

      // A read issued in the line-start cycle belongs to the abandoned fill, so it is not captured.
      if (iLineStart) begin
         front_d    = ~front_q;
         disp_ptr_d = '0;
         base_d     = ADDR_W'(line_sel) * ADDR_W'(H_PIXELS);
         fill_idx_d = '0;
         slot_cnt_d = '0;
         state_d    = ST_FILL;
         disp_en_d  = 1'b1;
         rd_pend_d  = 1'b0;
         if (state_q != ST_IDLE) underrun_d = 1'b1;
      end
   end

   always_ff @(posedge iClk or negedge inRst) begin
      if (!inRst) begin
         state_q    <= ST_IDLE;
         front_q    <= 1'b0;
         disp_ptr_q <= '0;
         fill_idx_q <= '0;
         slot_cnt_q <= '0;
         base_q     <= '0;
         underrun_q <= 1'b0;
         disp_en_q  <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_idx_q   <= '0;
         rd_buf_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         front_q    <= front_d;
         disp_ptr_q <= disp_ptr_d;
         fill_idx_q <= fill_idx_d;
         slot_cnt_q <= slot_cnt_d;
         base_q     <= base_d;
         underrun_q <= underrun_d;
         disp_en_q  <= disp_en_d;
         rd_pend_q  <= rd_pend_d;
         rd_idx_q   <= rd_idx_d;
         rd_buf_q   <= rd_buf_d;
      end
   end

   always_ff @(posedge iClk) begin
      if (rd_pend_q) begin
         if (rd_buf_q) buf1[rd_idx_q] <= iMemRData;
         else          buf0[rd_idx_q] <= iMemRData;
      end
   end

   assign pix          = front_q ? buf1[disp_ptr_q] : buf0[disp_ptr_q];
   assign {oR, oG, oB} = disp_en_q ? pix : 24'd0;
   assign oMemAddr     = mem_addr;
   assign oMemRd       = mem_rd;
   assign oMemWr       = mem_wr;
   assign oMemWData    = mem_wdata;
   assign oWrAck       = wr_ack;
   assign oBusy        = (state_q == ST_FILL) || (state_q == ST_DRAIN);
   assign oUnderrun    = underrun_q;
   assign oFsmState    = state_q;

endmodule

// File: tb/tb_vga_line_prefetcher.sv
// Bench for vga_line_prefetcher: frame-memory model, scoreboard queues for reads, writes and
// displayed pixels, and directed line-start sequences.
module tb_vga_line_prefetcher;

   localparam int H         = 640;
   localparam int ADDR_W    = 19;
   localparam int MEM_WORDS = 307200;

   logic              clk = 1'b0;
   logic              inRst;
   logic              iLineStart;
   logic [9:0]        iLineNum;
   logic              iDataRequest;
   logic [7:0]        oR, oG, oB;
   logic [ADDR_W-1:0] oMemAddr;
   logic              oMemRd, oMemWr;
   logic [23:0]       oMemWData;
   logic [23:0]       mem_rdata;
   logic              iWrReq;
   logic [ADDR_W-1:0] iWrAddr;
   logic [23:0]       iWrData;
   logic              oWrAck, oBusy, oUnderrun;
   logic [1:0]        oFsmState;

   logic [23:0]       fmem [MEM_WORDS];
   logic [ADDR_W-1:0] exp_rd_q [$];
   logic [23:0]       exp_pix_q [$];
   logic [42:0]       exp_wr_q [$];
   int                n_checks = 0;
   int                n_errors = 0;

   always #5 clk = ~clk;

   vga_line_prefetcher dut (
      .iClk(clk), .inRst(inRst), .iLineStart(iLineStart), .iLineNum(iLineNum),
      .iDataRequest(iDataRequest), .oR(oR), .oG(oG), .oB(oB), .oMemAddr(oMemAddr),
      .oMemRd(oMemRd), .oMemWr(oMemWr), .oMemWData(oMemWData), .iMemRData(mem_rdata),
      .iWrReq(iWrReq), .iWrAddr(iWrAddr), .iWrData(iWrData), .oWrAck(oWrAck),
      .oBusy(oBusy), .oUnderrun(oUnderrun), .oFsmState(oFsmState)
   );

   function automatic logic [23:0] pat(input int a);
      return 24'(a) ^ 24'h3C0000;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame memory: 1-cycle read latency, write on the strobe edge.
   always @(posedge clk) begin
      if (oMemRd && int'(oMemAddr) < MEM_WORDS) mem_rdata <= fmem[oMemAddr];
      if (oMemWr && int'(oMemAddr) < MEM_WORDS) fmem[oMemAddr] <= oMemWData;
   end

   always @(negedge clk) begin
      if (inRst) begin
         if (oMemRd || oMemWr) check("rd_wr_exclusive", {63'd0, oMemRd & oMemWr}, 64'd0);
         if (oMemRd) begin
            if (exp_rd_q.size() == 0) check("unexpected_read", {45'd0, oMemAddr}, 64'hFFFF_FFFF);
            else check("rd_addr", {45'd0, oMemAddr}, {45'd0, exp_rd_q.pop_front()});
         end
         if (oMemWr || oWrAck) begin
            check("wr_ack_with_wr", {63'd0, oWrAck}, {63'd0, oMemWr});
            if (exp_wr_q.size() == 0) check("unexpected_write", {21'd0, oMemAddr, oMemWData}, 64'hFFFF_FFFF);
            else check("wr_addr_data", {21'd0, oMemAddr, oMemWData}, {21'd0, exp_wr_q.pop_front()});
         end
         if (iDataRequest) begin
            if (exp_pix_q.size() == 0) check("unexpected_pixel", {40'd0, oR, oG, oB}, 64'hFFFF_FFFF);
            else check("pixel", {40'd0, oR, oG, oB}, {40'd0, exp_pix_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic line_start(input int n);
      iLineNum   = 10'(n);
      iLineStart = 1'b1;
      tick();
      iLineStart = 1'b0;
   endtask

   task automatic push_reads(input int line, input int n);
      for (int i = 0; i < n; i++) exp_rd_q.push_back(ADDR_W'(line * H + i));
   endtask

   task automatic push_pix(input int line, input int n, input int ovr_idx, input logic [23:0] ovr_val);
      for (int i = 0; i < n; i++) exp_pix_q.push_back((i == ovr_idx) ? ovr_val : pat(line * H + i));
   endtask

   // Requests n_req pixels while counting busy cycles until the fill has finished.
   task automatic run_line(input int n_req, output int busy_n);
      logic b;
      busy_n = 0;
      for (int c = 0; c < 3000; c++) begin
         iDataRequest = (c < n_req);
         @(negedge clk);
         b = oBusy;
         if (b) busy_n++;
         tick();
         if (!b && c >= n_req) break;
      end
      iDataRequest = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int  busy_n, acks, wk;
      logic a, b;
      for (int i = 0; i < MEM_WORDS; i++) fmem[i] = pat(i);
      mem_rdata    = '0;
      inRst        = 1'b0;
      iLineStart   = 1'b0;
      iLineNum     = '0;
      iDataRequest = 1'b0;
      iWrReq       = 1'b0;
      iWrAddr      = '0;
      iWrData      = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_rd", {63'd0, oMemRd}, 64'd0);
      check("rst_mem_wr", {63'd0, oMemWr}, 64'd0);
      check("rst_wr_ack", {63'd0, oWrAck}, 64'd0);
      check("rst_busy", {63'd0, oBusy}, 64'd0);
      check("rst_underrun", {63'd0, oUnderrun}, 64'd0);
      check("rst_rgb", {40'd0, oR, oG, oB}, 64'd0);
      check("rst_mem_addr", {45'd0, oMemAddr}, 64'd0);
      check("rst_state", {62'd0, oFsmState}, 64'd0);
      tick();
      inRst = 1'b1;
      repeat (2) tick();

      // Line 0 fill, no writer
      push_reads(0, H);
      line_start(0);
      run_line(0, busy_n);
      check("busy_cycles_line0", 64'(busy_n), 64'd641);

      // Display line 0 (plus one saturated request) while line 479 fills
      push_pix(0, H, -1, 24'd0);
      exp_pix_q.push_back(pat(H - 1));
      exp_rd_q.push_back(ADDR_W'(306560));
      for (int i = 1; i < H; i++) exp_rd_q.push_back(ADDR_W'(306560 + i));
      line_start(479);
      run_line(H + 1, busy_n);
      check("busy_cycles_line479", 64'(busy_n), 64'd641);

      // Writer held high through a fill of line 2
      push_reads(2, H);
      line_start(2);
      wk      = 0;
      iWrAddr = 19'h40000;
      iWrData = 24'hF00000;
      iWrReq  = 1'b1;
      exp_wr_q.push_back({iWrAddr, iWrData});
      busy_n  = 0;
      acks    = 0;
      for (int fc = 0; fc < 2000; fc++) begin
         @(negedge clk);
         b = oBusy;
         a = oWrAck;
         if (!b) break;
         busy_n++;
         if (a && fc < 731) begin
            acks++;
            check("wr_slot_pos", 64'(fc % 8), 64'd7);
         end
         tick();
         if (a) begin
            wk++;
            iWrAddr = 19'h40000 + 19'(wk);
            iWrData = 24'hF00000 + 24'(wk);
            exp_wr_q.push_back({iWrAddr, iWrData});
         end
      end
      tick();
      iWrReq = 1'b0;
      check("busy_cycles_with_writer", 64'(busy_n), 64'd732);
      check("writer_slots_in_fill", 64'(acks), 64'd91);

      // Zero-latency write while idle
      iWrAddr = 19'h12345;
      iWrData = 24'hA5B6C7;
      iWrReq  = 1'b1;
      exp_wr_q.push_back({iWrAddr, iWrData});
      @(negedge clk);
      check("idle_wr_strobe", {63'd0, oMemWr}, 64'd1);
      check("idle_wr_ack", {63'd0, oWrAck}, 64'd1);
      tick();
      iWrReq = 1'b0;

      // Display line 2 while line 116 fills; then line 116 (holds the written word) while line 9 fills
      push_pix(2, H, -1, 24'd0);
      push_reads(116, H);
      line_start(116);
      run_line(H, busy_n);
      check("busy_cycles_line116", 64'(busy_n), 64'd641);
      push_pix(116, H, 325, 24'hA5B6C7);
      push_reads(9, H);
      line_start(9);
      run_line(H, busy_n);
      check("busy_cycles_line9", 64'(busy_n), 64'd641);

      // Early line start 300 cycles into the fill of line 3
      check("underrun_before", {63'd0, oUnderrun}, 64'd0);
      push_reads(3, 300);
      push_reads(5, H);
      push_pix(9, 299, -1, 24'd0);
      push_pix(3, 10, -1, 24'd0);
      line_start(3);
      for (int c = 0; c < 299; c++) begin
         iDataRequest = 1'b1;
         tick();
      end
      iDataRequest = 1'b0;
      line_start(5);
      run_line(10, busy_n);
      check("busy_cycles_refill", 64'(busy_n), 64'd641);
      check("underrun_sticky", {63'd0, oUnderrun}, 64'd1);

      // Reset mid-fill
      push_pix(5, 5, -1, 24'd0);
      push_reads(0, 100);
      line_start(0);
      for (int c = 0; c < 100; c++) begin
         iDataRequest = (c < 5);
         tick();
      end
      iDataRequest = 1'b0;
      check("busy_before_reset", {63'd0, oBusy}, 64'd1);
      #2 inRst = 1'b0;
      #1;
      check("rst_async_rd", {63'd0, oMemRd}, 64'd0);
      check("rst_async_busy", {63'd0, oBusy}, 64'd0);
      check("rst_async_state", {62'd0, oFsmState}, 64'd0);
      repeat (3) tick();
      inRst = 1'b1;
      repeat (20) tick();
      @(negedge clk);
      check("post_rst_busy", {63'd0, oBusy}, 64'd0);
      check("post_rst_state", {62'd0, oFsmState}, 64'd0);
      check("post_rst_underrun", {63'd0, oUnderrun}, 64'd0);
      check("post_rst_rgb", {40'd0, oR, oG, oB}, 64'd0);

      check("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);
      check("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
      check("pix_queue_drained", 64'(exp_pix_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vga_line_prefetcher.md
Name: vga_line_prefetcher

Overview:
- Ping-pong line buffer plus memory scheduler between the frame memory and the VGA timing generator.
- On each line-start pulse it swaps buffers and prefetches the next display line from a single-port, 1-cycle-latency frame memory.
- While prefetching, it shares that memory port with one pixel-writer requester, such as a camera or drawing engine.
- The front buffer feeds the timing generator's 8-bit R/G/B inputs, one pixel per data-request cycle.

Parameters:
- H_PIXELS, 640, pixels per active line; equals the line-buffer depth.
- V_LINES, 480, active lines per frame; line-number range.
- ADDR_W, 19, frame-memory word address width.
- WR_SLOT, 8, during FILL every WR_SLOT-th cycle is reserved for the writer.

Ports:
- iClk, input, 1, system/pixel clock.
- inRst, input, 1, asynchronous active-low reset.
- iLineStart, input, 1, one-cycle pulse at least H_PIXELS*WR_SLOT/(WR_SLOT-1) cycles before the next active line.
- iLineNum, input, 10, line to prefetch; sampled on iLineStart.
- iDataRequest, input, 1, timing generator is consuming one pixel this cycle.
- oR / oG / oB, output, 8 each, current front-buffer pixel.
- oMemAddr, output, ADDR_W, frame-memory address.
- oMemRd, output, 1, memory read strobe.
- oMemWr, output, 1, memory write strobe.
- oMemWData, output, 24, write data {R,G,B}.
- iMemRData, input, 24, read data; valid the cycle after oMemRd.
- iWrReq, input, 1, writer request; held with address/data until acked.
- iWrAddr, input, ADDR_W, writer address.
- iWrData, input, 24, writer pixel.
- oWrAck, output, 1, one-cycle pulse: write issued this cycle.
- oBusy, output, 1, FILL in progress.
- oUnderrun, output, 1, sticky: a line start arrived before the fill finished.

Behaviour:
- Reset (inRst low, asynchronous):
  - FSM goes to IDLE; front select = 0; fill and display pointers = 0.
  - oMemRd, oMemWr, oWrAck, oBusy and oUnderrun = 0; oR/oG/oB = 0; oMemAddr = 0.
  - Buffer contents are undefined.
- FSM states:
  - IDLE: writer owns the port. On iLineStart, go to FILL.
  - FILL: issue reads. Move to DRAIN after read index H_PIXELS-1 is issued.
  - DRAIN: one cycle that captures the last read datum, then go to IDLE.
- iLineStart in any state:
  - Toggle front select and reset the display pointer to 0.
  - Latch base address = iLineNum*H_PIXELS (arithmetic in ADDR_W bits; iLineNum >= V_LINES gives undefined data, no error).
  - Reset the fill index to 0 and enter FILL.
  - If the previous state was FILL or DRAIN, set oUnderrun; the in-flight fill is abandoned.
- FILL cycle counter runs 0..WR_SLOT-1:
  - On counter value WR_SLOT-1 with iWrReq high, the cycle is a writer slot: oMemWr=1, oWrAck=1, no read issued.
  - Otherwise: oMemRd=1, oMemAddr = base + fill index, fill index +1.
  - An unused writer slot, with iWrReq low, issues a read instead.
- Read data: iMemRData is written into the back buffer at (fill index of the issuing cycle) on the following cycle. The pipeline keeps that index through one register stage.
- IDLE/DRAIN write path: when iWrReq is high, the write is issued the same cycle (oMemWr=1, oMemAddr=iWrAddr, oMemWData=iWrData, oWrAck=1). Write latency is 0 cycles from request when not in FILL.
- oWrAck is never asserted on two consecutive cycles for the same request. The writer drops or updates iWrReq the cycle after the ack.
- Display path:
  - oR/oG/oB = front buffer[display pointer], a combinational read; the VGA block gates blanking itself.
  - The display pointer increments on iDataRequest and saturates at H_PIXELS-1.
- oBusy = 1 in FILL and DRAIN.
- oMemRd and oMemWr are never both 1.
- oUnderrun clears only on reset.

Test Plan:
- Reset, then iLineStart with iLineNum=0 and no writer → 640 consecutive oMemRd, addresses 0..639, oBusy high for 641 cycles. After the next iLineStart, iDataRequest ×640 outputs memory model words 0..639 in order.
- iLineNum=479 → first read address 306560, last 307199.
- iWrReq held high throughout FILL → oWrAck on fill cycles 7, 15, 23, …; fill completes in 731 cycles; no read/write overlap.
- iWrReq in IDLE with iWrAddr=0x12345, iWrData=0xA5B6C7 → oMemWr=1 and oWrAck=1 in that same cycle; memory model updated.
- Second iLineStart 300 cycles after the first → oUnderrun=1, buffers swap, a new fill starts at the new base with fill index 0.
- inRst pulsed low mid-FILL → oMemRd/oBusy drop immediately (asynchronously); after release the FSM stays in IDLE until iLineStart.
